serv_wb_arbiter: RTL and testbench

Two-to-one Wishbone-classic arbiter that lets the SERV core's instruction bus (read-only) and data bus (read/write) share one memory port. Sits between `serv_top` and the single external memory/peripheral slave. Grants one requester at a time with round-robin tie-breaking and registers the master-side request. A bounded-wait watchdog terminates transactions the slave never acknowledges with an error response.

---
 rtl/serv_wb_arbiter_if.sv | 51 +++++
 rtl/serv_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_serv_wb_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_wb_arbiter_if.sv
// Bus bundle between the SERV ibus/dbus requesters, the arbiter and
// the shared Wishbone-classic memory port.
interface serv_wb_arbiter_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        o_err;
  logic [1:0]  o_grant;

  modport master (
    input  i_ibus_adr, i_ibus_cyc,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel,
    input  i_dbus_we, i_dbus_cyc,
    input  i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack,
    output o_dbus_rdt, o_dbus_ack,
    output o_wb_adr, o_wb_dat, o_wb_sel,
    output o_wb_we, o_wb_cyc,
    output o_err, o_grant
  );

  modport slave (
    output i_ibus_adr, i_ibus_cyc,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel,
    output i_dbus_we, i_dbus_cyc,
    output i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_wb_adr, o_wb_dat, o_wb_sel,
    input  o_wb_we, o_wb_cyc,
    input  o_err, o_grant
  );
endinterface

// File: rtl/serv_wb_arbiter.sv
// Round-robin 2:1 Wishbone arbiter for SERV ibus/dbus with a
// slave-ack watchdog that completes hung cycles with an error.
module serv_wb_arbiter #(
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic              clk,
  input logic              i_rst,
  serv_wb_arbiter_if.master bus
);

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt;

  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;

  logic wb_cyc;
  logic own_cyc;
  logic pick_d;
  logic pick_i;
  logic tmo;
  logic done;

  // last: 0 = ibus was served last, 1 = dbus
  assign pick_d = bus.i_dbus_cyc &
                  (~bus.i_ibus_cyc | ~last);
  assign pick_i = bus.i_ibus_cyc & ~pick_d;

  assign wb_cyc = (state != IDLE);

  always_comb begin
    own_cyc = 1'b0;
    unique case (1'b1)
      (state == IBUS): own_cyc = bus.i_ibus_cyc;
      (state == DBUS): own_cyc = bus.i_dbus_cyc;
      default:         own_cyc = 1'b0;
    endcase
  end

  // An aborting owner suppresses both slave and watchdog acks
  assign tmo = WD_EN & wb_cyc & own_cyc &
               ~bus.i_wb_ack & (cnt == TMO_LAST);
  assign done = wb_cyc & own_cyc &
                (bus.i_wb_ack | tmo);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_d:  state_nxt = DBUS;
          pick_i:  state_nxt = IBUS;
          default: state_nxt = IDLE;
        endcase
      end
      IBUS, DBUS: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = IDLE;
          last_nxt  = (state == DBUS);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      last   <= 1'b0;
      cnt    <= '0;
      wb_adr <= '0;
      wb_dat <= '0;
      wb_sel <= '0;
      wb_we  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (pick_d) begin
          wb_adr <= bus.i_dbus_adr;
          wb_dat <= bus.i_dbus_dat;
          wb_sel <= bus.i_dbus_sel;
          wb_we  <= bus.i_dbus_we;
        end else if (pick_i) begin
          wb_adr <= bus.i_ibus_adr;
          wb_dat <= '0;
          wb_sel <= 4'hF;
          wb_we  <= 1'b0;
        end
      end else if (WD_EN && !bus.i_wb_ack) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  logic [31:0] rdt;
  assign rdt = tmo ? ERR_DATA : bus.i_wb_rdt;

  assign bus.o_ibus_rdt = rdt;
  assign bus.o_dbus_rdt = rdt;
  assign bus.o_ibus_ack = done & (state == IBUS);
  assign bus.o_dbus_ack = done & (state == DBUS);
  assign bus.o_err      = tmo;

  assign bus.o_wb_adr = wb_adr;
  assign bus.o_wb_dat = wb_dat;
  assign bus.o_wb_sel = wb_sel;
  assign bus.o_wb_we  = wb_we;
  assign bus.o_wb_cyc = wb_cyc;
  assign bus.o_grant  = {state == DBUS, state == IBUS};

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Scoreboard bench for serv_wb_arbiter: directed transactions push
// expected grants/responses, a negedge monitor pops and compares.
module tb_serv_wb_arbiter;

  logic clk = 1'b0;
  logic i_rst;

  always #5 clk = ~clk;

  serv_wb_arbiter_if bus ();

  serv_wb_arbiter #(
    .TIMEOUT (4),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [1:0]  grant;
  } req_t;

  typedef struct {
    logic        d;
    logic [31:0] rdt;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic evt_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s unexpected event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string name,
                          output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (bus.o_wb_cyc) return;
    end
    evt_fail({name, "_timeout"});
  endtask

  // Monitor: master request on cyc rise, requester responses on ack
  logic prev_cyc = 1'b0;
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    logic ack_any;
    rsp_t r;
    req_t q;
    ack_any = bus.o_ibus_ack | bus.o_dbus_ack;
    if (bus.o_wb_cyc && !prev_cyc) begin
      if (req_q.size() == 0) begin
        evt_fail("req_unexpected");
      end else begin
        q = req_q.pop_front();
        cur = q;
        chk("req_adr", bus.o_wb_adr, q.adr);
        chk("req_dat", bus.o_wb_dat, q.dat);
        chk("req_sel", 32'(bus.o_wb_sel), 32'(q.sel));
        chk("req_we", 32'(bus.o_wb_we), 32'(q.we));
        chk("req_grant", 32'(bus.o_grant),
            32'(q.grant));
      end
    end else if (bus.o_wb_cyc) begin
      chk("hold_adr", bus.o_wb_adr, cur.adr);
      chk("hold_dat", bus.o_wb_dat, cur.dat);
    end
    if (ack_any) begin
      if (prev_ack) evt_fail("ack_repeat");
      if (rsp_q.size() == 0) begin
        evt_fail("ack_unexpected");
      end else begin
        r = rsp_q.pop_front();
        chk("ack_chan",
            32'({bus.o_dbus_ack, bus.o_ibus_ack}),
            r.d ? 32'd2 : 32'd1);
        chk("ack_rdt",
            r.d ? bus.o_dbus_rdt : bus.o_ibus_rdt,
            r.rdt);
        chk("ack_err", 32'(bus.o_err), 32'(r.err));
      end
    end else if (bus.o_err) begin
      evt_fail("err_without_ack");
    end
    prev_cyc = bus.o_wb_cyc;
    prev_ack = ack_any;
  end

  task automatic push_req(input logic [31:0] adr,
                          input logic [31:0] dat,
                          input logic [3:0] sel,
                          input logic we,
                          input logic [1:0] g);
    req_t q;
    q.adr = adr;
    q.dat = dat;
    q.sel = sel;
    q.we = we;
    q.grant = g;
    req_q.push_back(q);
  endtask

  task automatic push_rsp(input logic d,
                          input logic [31:0] rdt,
                          input logic err);
    rsp_t r;
    r.d = d;
    r.rdt = rdt;
    r.err = err;
    rsp_q.push_back(r);
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    bus.i_ibus_adr = '0;
    bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = '0;
    bus.i_dbus_dat = '0;
    bus.i_dbus_sel = '0;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt   = '0;
    bus.i_wb_ack   = 1'b0;
    step();
    step();
    chk("rst_cyc", 32'(bus.o_wb_cyc), 0);
    chk("rst_grant", 32'(bus.o_grant), 0);
    chk("rst_adr", bus.o_wb_adr, 0);
    chk("rst_sel", 32'(bus.o_wb_sel), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    i_rst = 1'b0;
    step();

    // ibus fetch, slave acks two cycles after cyc
    bus.i_ibus_adr = 32'h100;
    bus.i_ibus_cyc = 1'b1;
    push_req(32'h100, 0, 4'hF, 1'b0, 2'b01);
    push_rsp(1'b0, 32'h13, 1'b0);
    wait_cyc("ibus", n);
    chk("ibus_lat", n, 1);
    step();
    step();
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'h13;
    chk("ibus_dack", 32'(bus.o_dbus_ack), 0);
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_ibus_cyc = 1'b0;
    chk("ibus_cyc_off", 32'(bus.o_wb_cyc), 0);
    chk("ibus_grant_off", 32'(bus.o_grant), 0);
    step();

    // dbus write
    bus.i_dbus_adr = 32'h2000;
    bus.i_dbus_dat = 32'hA5A5_A5A5;
    bus.i_dbus_sel = 4'h3;
    bus.i_dbus_we  = 1'b1;
    bus.i_dbus_cyc = 1'b1;
    push_req(32'h2000, 32'hA5A5_A5A5, 4'h3, 1'b1,
             2'b10);
    push_rsp(1'b1, 32'h0, 1'b0);
    wait_cyc("dbus", n);
    bus.i_dbus_dat = 32'h0;
    bus.i_dbus_adr = 32'h9999;
    step();
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'h0;
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_dbus_cyc = 1'b0;
    chk("dbus_cyc_off", 32'(bus.o_wb_cyc), 0);
    step();

    // contested request right after reset
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    bus.i_ibus_adr = 32'h104;
    bus.i_ibus_cyc = 1'b1;
    bus.i_dbus_adr = 32'h3000;
    bus.i_dbus_dat = 32'h0;
    bus.i_dbus_sel = 4'hF;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_cyc = 1'b1;
    push_req(32'h3000, 0, 4'hF, 1'b0, 2'b10);
    push_rsp(1'b1, 32'h1111_1111, 1'b0);
    push_req(32'h104, 0, 4'hF, 1'b0, 2'b01);
    push_rsp(1'b0, 32'h2222_2222, 1'b0);
    wait_cyc("tie1", n);
    chk("tie_grant1", 32'(bus.o_grant), 2);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'h1111_1111;
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_dbus_cyc = 1'b0;
    wait_cyc("tie2", n);
    chk("b2b_gap", n, 1);
    chk("tie_grant2", 32'(bus.o_grant), 1);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'h2222_2222;
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_ibus_cyc = 1'b0;
    step();

    // watchdog: slave never acks
    bus.i_ibus_adr = 32'h200;
    bus.i_ibus_cyc = 1'b1;
    push_req(32'h200, 0, 4'hF, 1'b0, 2'b01);
    push_rsp(1'b0, 32'hDEAD_BEEF, 1'b1);
    wait_cyc("wd", n);
    step();
    step();
    chk("wd_early", 32'(bus.o_ibus_ack), 0);
    step();
    chk("wd_ack", 32'(bus.o_ibus_ack), 1);
    chk("wd_err", 32'(bus.o_err), 1);
    step();
    bus.i_ibus_cyc = 1'b0;
    chk("wd_cyc_off", 32'(bus.o_wb_cyc), 0);
    step();

    // watchdog boundary: slave ack on the last cycle wins
    bus.i_ibus_adr = 32'h204;
    bus.i_ibus_cyc = 1'b1;
    push_req(32'h204, 0, 4'hF, 1'b0, 2'b01);
    push_rsp(1'b0, 32'hCAFE_0001, 1'b0);
    wait_cyc("wd2", n);
    step();
    step();
    step();
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'hCAFE_0001;
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_ibus_cyc = 1'b0;
    chk("wd2_cyc_off", 32'(bus.o_wb_cyc), 0);
    step();

    // abort: dbus drops one cycle into the grant
    bus.i_dbus_adr = 32'h4000;
    bus.i_dbus_sel = 4'hF;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_cyc = 1'b1;
    push_req(32'h4000, 0, 4'hF, 1'b0, 2'b10);
    wait_cyc("abort", n);
    step();
    bus.i_dbus_cyc = 1'b0;
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'h7777_7777;
    chk("abort_dack", 32'(bus.o_dbus_ack), 0);
    step();
    chk("abort_cyc_off", 32'(bus.o_wb_cyc), 0);
    step();
    bus.i_wb_ack = 1'b0;
    step();

    // async reset mid-transaction, request still pending
    bus.i_ibus_adr = 32'h300;
    bus.i_ibus_cyc = 1'b1;
    wait_cyc("rst_mid", n);
    chk("rst_mid_grant", 32'(bus.o_grant), 1);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'h55;
    #1;
    i_rst = 1'b1;
    #1;
    chk("amid_cyc", 32'(bus.o_wb_cyc), 0);
    chk("amid_grant", 32'(bus.o_grant), 0);
    chk("amid_adr", bus.o_wb_adr, 0);
    chk("amid_ack", 32'(bus.o_ibus_ack), 0);
    bus.i_wb_ack = 1'b0;
    push_req(32'h300, 0, 4'hF, 1'b0, 2'b01);
    push_rsp(1'b0, 32'h55, 1'b0);
    step();
    i_rst = 1'b0;
    wait_cyc("rst_regrant", n);
    chk("regrant_lat", n, 1);
    bus.i_wb_ack = 1'b1;
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_ibus_cyc = 1'b0;
    step();
    step();

    chk("req_q_empty", req_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
